dmem_access_ctrl: RTL and testbench

- Two-port access controller and arbiter in front of the word-addressed data memory.
- Port 0 is the CPU load/store unit; port 1 is the DMA/debug requester.
- Serialises requests onto the single memory interface (dm_w/dm_r/store_format_signal/dm_addr/dm_wdata/dm_rdata).
- Registers load data and applies sign/zero extension for sub-word loads.
- Fixed priority to port 0, with a starvation guard for port 1.

---
 rtl/dmem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Two-port load/store arbiter in front of the single-ported data memory.
// Optional DMEM_ACCESS_CTRL_PERF_EN adds grant/conflict performance counters.
module dmem_access_ctrl #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned ADDR_W       = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req_valid,
   output logic              p0_req_ready,
   input  logic              p0_we,
   input  logic [2:0]        p0_fmt,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [31:0]       p0_wdata,
   output logic              p0_rsp_valid,
   output logic [31:0]       p0_rdata,
   input  logic              p1_req_valid,
   output logic              p1_req_ready,
   input  logic              p1_we,
   input  logic [2:0]        p1_fmt,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [31:0]       p1_wdata,
   output logic              p1_rsp_valid,
   output logic [31:0]       p1_rdata,
   output logic              dm_w,
   output logic              dm_r,
   output logic [1:0]        store_format_signal,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [31:0]       dm_wdata,
   input  logic [31:0]       dm_rdata
`ifdef DMEM_ACCESS_CTRL_PERF_EN
   ,
   output logic [31:0]       perf_grant0,
   output logic [31:0]       perf_grant1,
   output logic [31:0]       perf_conflict
`endif
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;
   localparam logic [7:0] LIMIT  = 8'(STARVE_LIMIT);

   logic [0:0]        state_q;
   logic              we_q;
   logic [2:0]        fmt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              port_q;
   logic [7:0]        starve_cnt_q;
   logic              grant0, grant1, both_valid, in_access;
   logic [31:0]       ext_data;

   always_comb begin
      in_access  = (state_q == ACCESS);
      both_valid = p0_req_valid & p1_req_valid;
      grant1     = !in_access & p1_req_valid & (!p0_req_valid | (starve_cnt_q == LIMIT));
      grant0     = !in_access & p0_req_valid & !grant1;
   end

   assign p0_req_ready = grant0;
   assign p1_req_ready = grant1;

   // Memory bus is only driven during ACCESS; a format of 11 never strobes a write.
   always_comb begin
      dm_w                = 1'b0;
      dm_r                = 1'b0;
      store_format_signal = 2'b00;
      dm_addr             = '0;
      dm_wdata            = '0;
      if (in_access) begin
         dm_addr  = addr_q;
         dm_wdata = wdata_q;
         if (we_q) begin
            if (fmt_q[1:0] != 2'b11) begin
               dm_w                = 1'b1;
               store_format_signal = fmt_q[1:0];
            end
         end else begin
            dm_r = 1'b1;
         end
      end
   end

   always_comb begin
      case (fmt_q[1:0])
         2'b01:   ext_data = fmt_q[2] ? {16'h0000, dm_rdata[15:0]}
                                      : {{16{dm_rdata[15]}}, dm_rdata[15:0]};
         2'b10:   ext_data = fmt_q[2] ? {24'h000000, dm_rdata[7:0]}
                                      : {{24{dm_rdata[7]}}, dm_rdata[7:0]};
         default: ext_data = dm_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         fmt_q        <= 3'b000;
         addr_q       <= '0;
         wdata_q      <= '0;
         port_q       <= 1'b0;
         starve_cnt_q <= 8'd0;
         p0_rsp_valid <= 1'b0;
         p1_rsp_valid <= 1'b0;
         p0_rdata     <= '0;
         p1_rdata     <= '0;
      end else begin
         p0_rsp_valid <= 1'b0;
         p1_rsp_valid <= 1'b0;
         if (!in_access) begin
            if (grant0 | grant1) begin
               state_q <= ACCESS;
               port_q  <= grant1;
               we_q    <= grant1 ? p1_we    : p0_we;
               fmt_q   <= grant1 ? p1_fmt   : p0_fmt;
               addr_q  <= grant1 ? p1_addr  : p0_addr;
               wdata_q <= grant1 ? p1_wdata : p0_wdata;
            end
            if (grant1) begin
               starve_cnt_q <= 8'd0;
            end else if (both_valid && grant0 && starve_cnt_q != 8'hFF) begin
               starve_cnt_q <= starve_cnt_q + 8'd1;
            end
         end else begin
            state_q <= IDLE;
            if (port_q) p1_rsp_valid <= 1'b1;
            else        p0_rsp_valid <= 1'b1;
            if (!we_q) begin
               if (port_q) p1_rdata <= ext_data;
               else        p0_rdata <= ext_data;
            end
         end
      end
   end

`ifdef DMEM_ACCESS_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_grant0   <= 32'd0;
         perf_grant1   <= 32'd0;
         perf_conflict <= 32'd0;
      end else begin
         if (grant0) perf_grant0 <= perf_grant0 + 32'd1;
         if (grant1) perf_grant1 <= perf_grant1 + 32'd1;
         if (!in_access && both_valid) perf_conflict <= perf_conflict + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a small behavioural word memory.
// Perf counter checks are compiled in when DMEM_ACCESS_CTRL_PERF_EN is defined.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_req_valid, p0_req_ready, p0_we, p0_rsp_valid;
   logic [2:0]  p0_fmt;
   logic [10:0] p0_addr;
   logic [31:0] p0_wdata, p0_rdata;
   logic        p1_req_valid, p1_req_ready, p1_we, p1_rsp_valid;
   logic [2:0]  p1_fmt;
   logic [10:0] p1_addr;
   logic [31:0] p1_wdata, p1_rdata;
   logic        dm_w, dm_r;
   logic [1:0]  store_format_signal;
   logic [10:0] dm_addr;
   logic [31:0] dm_wdata, dm_rdata;
`ifdef DMEM_ACCESS_CTRL_PERF_EN
   logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

   logic [31:0] mem [0:2047];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl #(.STARVE_LIMIT(4), .ADDR_W(11)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_we(p0_we),
      .p0_fmt(p0_fmt), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_rsp_valid(p0_rsp_valid), .p0_rdata(p0_rdata),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_we(p1_we),
      .p1_fmt(p1_fmt), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_rsp_valid(p1_rsp_valid), .p1_rdata(p1_rdata),
      .dm_w(dm_w), .dm_r(dm_r), .store_format_signal(store_format_signal),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
`ifdef DMEM_ACCESS_CTRL_PERF_EN
      , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
   );

   assign dm_rdata = mem[dm_addr];

   always @(posedge clk) begin
      if (dm_w) begin
         case (store_format_signal)
            2'b01:   mem[dm_addr][15:0] <= dm_wdata[15:0];
            2'b10:   mem[dm_addr][7:0]  <= dm_wdata[7:0];
            default: mem[dm_addr]       <= dm_wdata;
         endcase
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Single-port transaction, entered and left just after a rising edge.
   task automatic access(input int p, input logic we, input logic [2:0] fmt,
                         input logic [10:0] addr, input logic [31:0] wd,
                         input logic exp_w, input logic [1:0] exp_sfs,
                         input logic [31:0] exp_rd);
      if (p == 0) begin
         p0_we = we; p0_fmt = fmt; p0_addr = addr; p0_wdata = wd; p0_req_valid = 1'b1;
      end else begin
         p1_we = we; p1_fmt = fmt; p1_addr = addr; p1_wdata = wd; p1_req_valid = 1'b1;
      end
      @(negedge clk);
      check_eq($sformatf("ready p%0d", p), (p == 0) ? p0_req_ready : p1_req_ready, 1);
      @(posedge clk); #1;
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b0;
      @(negedge clk);
      check_eq("acc dm_w", dm_w, exp_w);
      check_eq("acc dm_r", dm_r, !we);
      check_eq("acc dm_addr", dm_addr, addr);
      if (we && fmt[1:0] != 2'b11) check_eq("acc sfs", store_format_signal, exp_sfs);
      check_eq("acc no early rsp", p0_rsp_valid | p1_rsp_valid, 0);
      @(negedge clk);
      check_eq("rsp own", (p == 0) ? p0_rsp_valid : p1_rsp_valid, 1);
      check_eq("rsp other", (p == 0) ? p1_rsp_valid : p0_rsp_valid, 0);
      check_eq("rsp dm_w low", dm_w, 0);
      if (!we) check_eq("rdata", (p == 0) ? p0_rdata : p1_rdata, exp_rd);
      @(posedge clk); #1;
   endtask

   initial begin
      int          order [10];
      int          exp_order [10];
      int          n, cyc;
      logic [31:0] g0, g1, gc;
      exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
      mem[11'h010] = 32'h1234F08C;
      rst_n = 1'b0;
      p0_req_valid = 0; p0_we = 0; p0_fmt = 0; p0_addr = 0; p0_wdata = 0;
      p1_req_valid = 0; p1_we = 0; p1_fmt = 0; p1_addr = 0; p1_wdata = 0;
      #12;
      check_eq("rst dm_w", dm_w, 0);
      check_eq("rst dm_r", dm_r, 0);
      check_eq("rst dm_addr", dm_addr, 0);
      check_eq("rst rsp", p0_rsp_valid | p1_rsp_valid, 0);
      check_eq("rst p0_rdata", p0_rdata, 0);
      check_eq("rst p1_rdata", p1_rdata, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      access(0, 1, 3'b000, 11'h005, 32'hDEADBEEF, 1, 2'b00, 0);
      access(0, 0, 3'b000, 11'h005, 0, 0, 2'b00, 32'hDEADBEEF);
      access(0, 0, 3'b010, 11'h010, 0, 0, 2'b00, 32'hFFFFFF8C);
      access(0, 0, 3'b110, 11'h010, 0, 0, 2'b00, 32'h0000008C);
      access(0, 0, 3'b001, 11'h010, 0, 0, 2'b00, 32'hFFFFF08C);
      access(0, 0, 3'b101, 11'h010, 0, 0, 2'b00, 32'h0000F08C);

      access(1, 1, 3'b001, 11'h020, 32'hAABBCCDD, 1, 2'b01, 0);
      access(1, 1, 3'b010, 11'h020, 32'hAABBCCDD, 1, 2'b10, 0);
      access(1, 1, 3'b011, 11'h020, 32'h55667788, 0, 2'b00, 0);
      access(1, 0, 3'b000, 11'h020, 0, 0, 2'b00, 32'h0000CCDD);
      check_eq("p0_rdata held", p0_rdata, 32'h0000F08C);

      // Both ports hammering: watch the grant order.
`ifdef DMEM_ACCESS_CTRL_PERF_EN
      g0 = perf_grant0; g1 = perf_grant1; gc = perf_conflict;
`else
      g0 = 0; g1 = 0; gc = 0;
`endif
      p0_we = 0; p0_fmt = 0; p0_addr = 11'h005; p0_req_valid = 1;
      p1_we = 0; p1_fmt = 0; p1_addr = 11'h010; p1_req_valid = 1;
      n = 0;
      cyc = 0;
      while (n < 10 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (p0_req_ready && p1_req_ready) check_eq("dual ready", 1, 0);
         if (p0_req_ready) begin
            order[n] = 0; n++;
         end else if (p1_req_ready) begin
            order[n] = 1; n++;
         end
         @(posedge clk); #1;
         if (n > 0 && order[n-1] == 1 && p1_req_valid) check_eq("starve clr", dut.starve_cnt_q, 0);
         if (n == 10) begin
            p0_req_valid = 0;
            p1_req_valid = 0;
         end
      end
      p0_req_valid = 0;
      p1_req_valid = 0;
      if (n < 10) check_eq("starve timeout", n, 10);
      for (int i = 0; i < n; i++) check_eq($sformatf("grant %0d", i), order[i], exp_order[i]);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1;
`ifdef DMEM_ACCESS_CTRL_PERF_EN
      check_eq("perf_grant0", perf_grant0 - g0, 8);
      check_eq("perf_grant1", perf_grant1 - g1, 2);
      check_eq("perf_conflict", perf_conflict - gc, 10);
`endif

      // Reset in the middle of a store's ACCESS cycle.
      p0_we = 1; p0_fmt = 0; p0_addr = 11'h030; p0_wdata = 32'h11111111; p0_req_valid = 1;
      @(negedge clk);
      @(posedge clk); #1;
      p0_req_valid = 0;
      #2;
      check_eq("rst pre dm_w", dm_w, 1);
      rst_n = 1'b0;
      #1;
      check_eq("rst async dm_w", dm_w, 0);
      check_eq("rst async dm_addr", dm_addr, 0);
      @(posedge clk); #1;
      check_eq("rst no rsp", p0_rsp_valid | p1_rsp_valid, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("post rst no rsp", p0_rsp_valid | p1_rsp_valid, 0);
      check_eq("no partial write", mem[11'h030], 0);
      check_eq("post rst idle", dm_r | dm_w, 0);
      p0_req_valid = 1;
      #1;
      check_eq("post rst p0 ready", p0_req_ready, 1);
      p0_req_valid = 0;
      p1_req_valid = 1;
      #1;
      check_eq("post rst p1 ready", p1_req_ready, 1);
      p1_req_valid = 0;
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
